// File: rtl/dds_wave_gen_if.sv
// Control and sample bundle between a DDS client and dds_wave_gen.
// Latency: none, this file only carries signals.
// Backpressure: none; the generator always produces samples and the sink must keep up.
interface dds_wave_gen_if #(
   parameter int ACC_W = 16,
   parameter int OUT_W = 8
);
   logic             i_en;
   logic             i_ftw_load;
   logic [ACC_W-1:0] i_ftw_in;
   logic [1:0]       i_mode;
   logic [OUT_W-1:0] o_magnitude;
   logic             o_valid;
   logic             o_cycle_done;

   // Client side: drives controls, observes samples.
   modport master (
      output i_en, i_ftw_load, i_ftw_in, i_mode,
      input  o_magnitude, o_valid, o_cycle_done
   );

   // Generator side.
   modport slave (
      input  i_en, i_ftw_load, i_ftw_in, i_mode,
      output o_magnitude, o_valid, o_cycle_done
   );
endinterface

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS: sine (quarter-wave ROM), triangle, sawtooth or square, offset-binary.
// Latency: magnitude/valid 2 cycles after the phase they represent; cycle_done 1 cycle after the wrapping step.
// Backpressure: none; one sample per clock, valid marks samples taken from an enabled step.
module dds_wave_gen #(
   parameter int ACC_W  = 16,
   parameter int LUT_AW = 6,
   parameter int OUT_W  = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   dds_wave_gen_if.slave bus
);

   // Only the top phase bits feed any waveform; keep just enough of them in the pipe.
   localparam int PH_W  = ((LUT_AW + 2) > (OUT_W + 1)) ? (LUT_AW + 2) : (OUT_W + 1);
   localparam int ROM_N = 1 << LUT_AW;

   localparam logic [OUT_W-1:0] MID  = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-2:0] PEAK = '1;

   localparam logic [1:0] MODE_SINE = 2'b00;
   localparam logic [1:0] MODE_TRI  = 2'b01;
   localparam logic [1:0] MODE_SAW  = 2'b10;
   localparam logic [1:0] MODE_SQR  = 2'b11;

   generate
      if ((LUT_AW + 2 > ACC_W) || (OUT_W + 1 > ACC_W)) begin : g_bad_params
         $error("dds_wave_gen: need LUT_AW+2 <= ACC_W and OUT_W+1 <= ACC_W");
      end
   endgenerate

   // Quarter-wave entry k = round((2^(OUT_W-1)-1) * sin(pi/2 * k / 2^LUT_AW)).
   // Evaluated with a Q30 fixed-point Taylor series so the table is built at
   // elaboration from the parameters instead of from an external image.
   function automatic logic [OUT_W-2:0] f_sine_entry(input int k);
      longint x;
      longint term;
      longint sum;
      longint amp;
      longint res;
      x    = (64'sd1686629713 * longint'(k)) >>> LUT_AW;
      term = x;
      sum  = x;
      for (int i = 1; i < 12; i++) begin
         term = (term * x) >>> 30;
         term = (term * x) >>> 30;
         term = -term / longint'((2 * i) * (2 * i + 1));
         sum  = sum + term;
      end
      amp = longint'((1 << (OUT_W - 1)) - 1);
      res = (sum * amp + (64'sd1 <<< 29)) >>> 30;
      return res[OUT_W-2:0];
   endfunction

   logic [OUT_W-2:0] w_rom [ROM_N];

   generate
      for (genvar k = 0; k < ROM_N; k++) begin : g_rom
         assign w_rom[k] = f_sine_entry(k);
      end
   endgenerate

   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_ftw;
   logic              r_cycle_done;
   logic [PH_W-1:0]   r_s1_ph;
   logic [1:0]        r_s1_mode;
   logic              r_s1_en;
   logic [OUT_W-1:0]  r_magnitude;
   logic              r_valid;

   logic [ACC_W:0]    w_sum;
   logic [LUT_AW+1:0] w_sp;
   logic [1:0]        w_q;
   logic [LUT_AW-1:0] w_idx;
   logic [LUT_AW-1:0] w_mir;
   logic [LUT_AW-1:0] w_addr;
   logic [OUT_W-2:0]  w_m;
   logic [OUT_W-1:0]  w_sine;
   logic [OUT_W:0]    w_t;
   logic [OUT_W-1:0]  w_tri;
   logic [OUT_W-1:0]  w_saw;
   logic [OUT_W-1:0]  w_sqr;
   logic [OUT_W-1:0]  w_mag_next;

   // Extra top bit of the sum is the wrap carry.
   assign w_sum = {1'b0, r_acc} + {1'b0, r_ftw};

   // Accumulator steps with the tuning word held this cycle; a load takes effect from the next step.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc        <= '0;
         r_ftw        <= '0;
         r_cycle_done <= 1'b0;
      end else begin
         if (bus.i_en) begin
            r_acc        <= w_sum[ACC_W-1:0];
            r_cycle_done <= w_sum[ACC_W];
         end else begin
            r_cycle_done <= 1'b0;
         end
         if (bus.i_ftw_load) begin
            r_ftw <= bus.i_ftw_in;
         end
      end
   end

   // Stage 1: snapshot phase, mode and enable so a mode change lands on a sample boundary.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_ph   <= '0;
         r_s1_mode <= '0;
         r_s1_en   <= 1'b0;
      end else begin
         r_s1_ph   <= r_acc[ACC_W-1 -: PH_W];
         r_s1_mode <= bus.i_mode;
         r_s1_en   <= bus.i_en;
      end
   end

   // Sine: fold the phase into the first quadrant. Odd quadrants read mirrored,
   // and idx 0 there is the peak, which sits one past the end of the table.
   assign w_sp   = r_s1_ph[PH_W-1 -: LUT_AW+2];
   assign w_q    = w_sp[LUT_AW+1:LUT_AW];
   assign w_idx  = w_sp[LUT_AW-1:0];
   assign w_mir  = {LUT_AW{1'b0}} - w_idx;
   assign w_addr = w_q[0] ? w_mir : w_idx;
   assign w_m    = (w_q[0] && (w_idx == '0)) ? PEAK : w_rom[w_addr];
   assign w_sine = w_q[1] ? (MID - {1'b0, w_m}) : (MID + {1'b0, w_m});

   assign w_t    = r_s1_ph[PH_W-1 -: OUT_W+1];
   assign w_tri  = w_t[OUT_W] ? ~w_t[OUT_W-1:0] : w_t[OUT_W-1:0];
   assign w_saw  = r_s1_ph[PH_W-1 -: OUT_W];
   assign w_sqr  = r_s1_ph[PH_W-1] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};

   // Waveform select for the stage-2 register.
   always_comb begin
      w_mag_next = MID;
      case (r_s1_mode)
         MODE_SINE: w_mag_next = w_sine;
         MODE_TRI:  w_mag_next = w_tri;
         MODE_SAW:  w_mag_next = w_saw;
         MODE_SQR:  w_mag_next = w_sqr;
         default:   w_mag_next = MID;
      endcase
   end

   // Stage 2: registered sample; the ROM lookup resolves into this register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_magnitude <= MID;
         r_valid     <= 1'b0;
      end else begin
         r_magnitude <= w_mag_next;
         r_valid     <= r_s1_en;
      end
   end

   assign bus.o_magnitude  = r_magnitude;
   assign bus.o_valid      = r_valid;
   assign bus.o_cycle_done = r_cycle_done;

endmodule
